// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, S-box contents and round-engine state encoding
package des_pkg;

    localparam int NUM_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Entry i names the DES (1-based) source bit of output bit i, counted from the MSB.
    // The helper functions turn those into MSB-first vector indices.
    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    // One 256-bit word per S-box: 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
        return y;
    endfunction

    // Row comes from the outer bits {b5,b0}, column from b4..b1.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] b);
        logic [5:0] idx;
        logic [7:0] msb;
        idx = {b[5], b[0], b[4:1]};
        msb = 8'd255 - {idx, 2'b00};
        return SBOX[n][msb -: 4];
    endfunction

endpackage

// File: rtl/des_f.sv
// rtl/des_f.sv - DES round function f(R, K): expansion, key mix, S-boxes, P
module des_f import des_pkg::*; (
    input  logic [31:0] r_i,
    input  logic [47:0] sk_i,
    output logic [31:0] f_o
);

    logic [47:0] x;
    logic [31:0] s;

    assign x = e_expand(r_i) ^ sk_i;

    // Group k of the mixed word feeds S-box k; S1 output lands in the top nibble.
    des_sbox1 u_s1 (.b_i(x[47:42]), .s_o(s[31:28]));
    des_sbox2 u_s2 (.b_i(x[41:36]), .s_o(s[27:24]));
    des_sbox3 u_s3 (.b_i(x[35:30]), .s_o(s[23:20]));
    des_sbox4 u_s4 (.b_i(x[29:24]), .s_o(s[19:16]));
    des_sbox5 u_s5 (.b_i(x[23:18]), .s_o(s[15:12]));
    des_sbox6 u_s6 (.b_i(x[17:12]), .s_o(s[11:8]));
    des_sbox7 u_s7 (.b_i(x[11:6]),  .s_o(s[7:4]));
    des_sbox8 u_s8 (.b_i(x[5:0]),   .s_o(s[3:0]));

    assign f_o = p_perm(s);

endmodule

// File: rtl/des_sbox.sv
// rtl/des_sbox.sv - the eight DES S-box lookups
module des_sbox1 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd0, b_i);
endmodule

module des_sbox2 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd1, b_i);
endmodule

module des_sbox3 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd2, b_i);
endmodule

module des_sbox4 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd3, b_i);
endmodule

module des_sbox5 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd4, b_i);
endmodule

module des_sbox6 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd5, b_i);
endmodule

module des_sbox7 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd6, b_i);
endmodule

module des_sbox8 import des_pkg::*; (input logic [5:0] b_i, output logic [3:0] s_o);
    assign s_o = sbox_lookup(3'd7, b_i);
endmodule

// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative DES engine, one Feistel round per clock
module des_round_engine import des_pkg::*; #(
    parameter bit HOLD_DOUT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        din_vld_i,
    output logic        din_rdy_o,
    input  logic [63:0] din_i,
    input  logic        dec_i,
    output logic [3:0]  sk_idx_o,
    input  logic [47:0] sk_i,
    output logic        dout_vld_o,
    input  logic        dout_rdy_i,
    output logic [63:0] dout_o,
    output logic        busy_o
);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] l_q, r_q, l_d, r_d;
    logic        dec_q;
    logic [63:0] dout_q;
    logic        dout_vld_q;
    logic [31:0] f;
    logic [63:0] ip_din;
    logic        last;

    des_f u_f (.r_i(r_q), .sk_i(sk_i), .f_o(f));

    assign l_d    = r_q;
    assign r_d    = l_q ^ f;
    assign ip_din = ip_perm(din_i);
    assign last   = (cnt_q == 4'(NUM_ROUNDS - 1));

    // A block may enter while the previous result is being handed off, so DONE is also ready.
    assign din_rdy_o  = (state_q == IDLE) || (state_q == DONE && dout_rdy_i);
    assign sk_idx_o   = (state_q == ROUND) ? (dec_q ? 4'd15 - cnt_q : cnt_q) : 4'd0;
    assign busy_o     = (state_q == ROUND) || (state_q == DONE);
    assign dout_o     = dout_q;
    assign dout_vld_o = dout_vld_q;

    // Handshake FSM, round counter and L/R datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            l_q        <= 32'd0;
            r_q        <= 32'd0;
            dec_q      <= 1'b0;
            dout_q     <= 64'd0;
            dout_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_vld_i) begin
                        {l_q, r_q} <= ip_din;
                        dec_q      <= dec_i;
                        cnt_q      <= 4'd0;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    l_q <= l_d;
                    r_q <= r_d;
                    if (last) begin
                        // The final round skips the swap, hence {L ^ f, R}.
                        dout_q     <= fp_perm({r_d, r_q});
                        dout_vld_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (dout_rdy_i) begin
                        dout_vld_q <= 1'b0;
                        if (!HOLD_DOUT) dout_q <= 64'd0;
                        if (din_vld_i) begin
                            {l_q, r_q} <= ip_din;
                            dec_q      <= dec_i;
                            cnt_q      <= 4'd0;
                            state_q    <= ROUND;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - self-checking bench for des_round_engine
module tb_des_round_engine;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] CT0  = 64'h8CA64DE9C1B123A7;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, din_vld, dec, dout_rdy;
    logic [63:0] din;
    logic        din_rdy, dout_vld, busy;
    logic [3:0]  sk_idx;
    logic [47:0] sk;
    logic [63:0] dout;
    logic        din_rdy0, dout_vld0, busy0;
    logic [3:0]  sk_idx0;
    logic [47:0] sk0;
    logic [63:0] dout0;

    logic [47:0] ks [16];
    logic [63:0] exp_q [$];
    logic [3:0]  idx_trace [$];
    int errors = 0;
    int checks = 0;

    assign sk  = ks[sk_idx];
    assign sk0 = ks[sk_idx0];

    des_round_engine #(.HOLD_DOUT(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .din_vld_i(din_vld), .din_rdy_o(din_rdy),
        .din_i(din), .dec_i(dec), .sk_idx_o(sk_idx), .sk_i(sk),
        .dout_vld_o(dout_vld), .dout_rdy_i(dout_rdy), .dout_o(dout), .busy_o(busy));

    des_round_engine #(.HOLD_DOUT(1'b0)) dut_clr (
        .clk_i(clk), .rst_i(rst), .din_vld_i(din_vld), .din_rdy_o(din_rdy0),
        .din_i(din), .dec_i(dec), .sk_idx_o(sk_idx0), .sk_i(sk0),
        .dout_vld_o(dout_vld0), .dout_rdy_i(dout_rdy), .dout_o(dout0), .busy_o(busy0));

    // Reference key schedule: PC1, per-round left rotations, PC2.
    task automatic load_key(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[4'(r)][6'(47 - j)] = cd[6'(56 - PC2[j])];
        end
    endtask

    // Presents one block at a negedge; returns at the negedge after the accept edge.
    task automatic start_block(input logic [63:0] d, input logic dc);
        din = d;
        dec = dc;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din = ~d;
        dec = ~dc;
    endtask

    // Counts edges since accept until dout_vld, logging sk_idx in every ROUND cycle.
    task automatic wait_vld(output int cyc);
        idx_trace.delete();
        cyc = 0;
        while (!dout_vld && cyc < 40) begin
            if (busy) idx_trace.push_back(sk_idx);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++; if (dout_vld !== 1'b0 || dout_vld0 !== 1'b0) begin errors++; $display("FAIL reset_dout_vld: got %b/%b expected 0", dout_vld, dout_vld0); end
        checks++; if (dout !== 64'd0 || dout0 !== 64'd0) begin errors++; $display("FAIL reset_dout: got %h/%h expected 0", dout, dout0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (din_rdy !== 1'b1) begin errors++; $display("FAIL reset_din_rdy: got %b expected 1", din_rdy); end
        checks++; if (sk_idx !== 4'd0) begin errors++; $display("FAIL reset_sk_idx: got %0d expected 0", sk_idx); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (din_rdy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got rdy=%b busy=%b expected rdy=1 busy=0", din_rdy, busy); end
    endtask

    task automatic test_encrypt();
        int cyc;
        logic [63:0] e;
        bit ok;
        load_key(KEY1);
        exp_q.push_back(CT1);
        start_block(PT1, 1'b0);
        wait_vld(cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL enc_latency: got %0d expected 16", cyc); end
        ok = (idx_trace.size() == 16);
        foreach (idx_trace[i]) if (idx_trace[i] !== 4'(i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL enc_sk_idx: got %0d entries/out of order expected 0..15", idx_trace.size()); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (dout !== e) begin errors++; $display("FAIL enc_dout: got %h expected %h", dout, e); end
        @(negedge clk);
        checks++; if (dout_vld !== 1'b0 || busy !== 1'b0 || din_rdy !== 1'b1) begin errors++; $display("FAIL enc_handoff: got vld=%b busy=%b rdy=%b expected 0 0 1", dout_vld, busy, din_rdy); end
    endtask

    task automatic test_decrypt();
        int cyc;
        logic [63:0] e;
        bit ok;
        load_key(KEY1);
        exp_q.push_back(PT1);
        start_block(CT1, 1'b1);
        wait_vld(cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL dec_latency: got %0d expected 16", cyc); end
        ok = (idx_trace.size() == 16);
        foreach (idx_trace[i]) if (idx_trace[i] !== 4'(15 - i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL dec_sk_idx: got %0d entries/out of order expected 15..0", idx_trace.size()); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (dout !== e) begin errors++; $display("FAIL dec_dout: got %h expected %h", dout, e); end
        @(negedge clk);
    endtask

    task automatic test_zero_key();
        int cyc;
        logic [63:0] e;
        load_key(64'd0);
        exp_q.push_back(CT0);
        start_block(64'd0, 1'b0);
        wait_vld(cyc);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (dout !== e) begin errors++; $display("FAIL zero_dout: got %h expected %h", dout, e); end
        checks++; if (dout0 !== e) begin errors++; $display("FAIL zero_dout_clr: got %h expected %h", dout0, e); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [63:0] e;
        load_key(KEY1);
        dout_rdy = 1'b0;
        exp_q.push_back(CT1);
        start_block(PT1, 1'b0);
        wait_vld(cyc);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (dout !== e) begin errors++; $display("FAIL bp_first_dout: got %h expected %h", dout, e); end
        for (int i = 0; i < 10; i++) begin
            din_vld = i[0];
            din = {$urandom, $urandom};
            dec = 1'b1;
            @(negedge clk);
            checks++;
            if (dout !== e || dout_vld !== 1'b1 || din_rdy !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got dout=%h vld=%b rdy=%b busy=%b expected %h 1 0 1", i, dout, dout_vld, din_rdy, busy, e);
            end
        end
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        #1;
        checks++; if (din_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_on_release: got %b expected 1", din_rdy); end
        exp_q.push_back(PT1);
        start_block(CT1, 1'b1);
        checks++; if (dout_vld !== 1'b0 || busy !== 1'b1 || din_rdy !== 1'b0) begin errors++; $display("FAIL bp_b2b_accept: got vld=%b busy=%b rdy=%b expected 0 1 0", dout_vld, busy, din_rdy); end
        wait_vld(cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL bp_second_latency: got %0d expected 16", cyc); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (dout !== e) begin errors++; $display("FAIL bp_second_dout: got %h expected %h", dout, e); end
        @(negedge clk);
    endtask

    task automatic test_hold_dout();
        int cyc;
        load_key(KEY1);
        start_block(PT1, 1'b0);
        wait_vld(cyc);
        checks++; if (dout0 !== CT1 || dout_vld0 !== 1'b1) begin errors++; $display("FAIL hold_clr_valid: got %h vld=%b expected %h 1", dout0, dout_vld0, CT1); end
        @(negedge clk);
        checks++; if (dout !== CT1) begin errors++; $display("FAIL hold1_after_handoff: got %h expected %h", dout, CT1); end
        checks++; if (dout0 !== 64'd0) begin errors++; $display("FAIL hold0_after_handoff: got %h expected 0", dout0); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [63:0] e;
        bit spurious;
        load_key(KEY1);
        start_block(PT1, 1'b0);
        repeat (7) @(negedge clk);
        checks++; if (busy !== 1'b1 || sk_idx !== 4'd7) begin errors++; $display("FAIL mid_before_reset: got busy=%b sk_idx=%0d expected 1 7", busy, sk_idx); end
        rst = 1'b1;
        #1;
        checks++; if (dout_vld !== 1'b0 || dout !== 64'd0) begin errors++; $display("FAIL mid_reset_out: got vld=%b dout=%h expected 0 0", dout_vld, dout); end
        checks++; if (busy !== 1'b0 || din_rdy !== 1'b1 || sk_idx !== 4'd0) begin errors++; $display("FAIL mid_reset_idle: got busy=%b rdy=%b sk_idx=%0d expected 0 1 0", busy, din_rdy, sk_idx); end
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout_vld !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        checks++; if (spurious) begin errors++; $display("FAIL mid_no_partial: got activity after reset expected none"); end
        exp_q.push_back(CT1);
        start_block(PT1, 1'b0);
        wait_vld(cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL mid_next_latency: got %0d expected 16", cyc); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (dout !== e) begin errors++; $display("FAIL mid_next_dout: got %h expected %h", dout, e); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        din_vld = 1'b0;
        din = 64'd0;
        dec = 1'b0;
        dout_rdy = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_zero_key();
        test_backpressure();
        test_hold_dout();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
- Iterative DES datapath, directly downstream of the eight S-box lookups: consumes their 32-bit concatenated output through the P permutation.
- Owns IP, L/R state, E expansion, subkey XOR, the Feistel swap and FP; executes one round per clock, 16 rounds per block.
- Subkeys come from an external key-schedule block, indexed by sk_idx.
- Sits between the block-level input/output handshake and the key schedule inside the DES top.

Parameters:
- HOLD_DOUT, 1: 1 = dout holds its last value after hand-off; 0 = dout clears to 0 on the hand-off edge.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din_vld  in  1  input block valid
- din_rdy  out  1  engine can accept a block
- din  in  64  plaintext/ciphertext, bit 63 = DES bit 1
- dec  in  1  sampled with din; 1 = decrypt
- sk_idx  out  4  subkey index requested this cycle
- sk  in  48  subkey K(sk_idx), combinational from key schedule, bit 47 = DES bit 1
- dout_vld  out  1  result valid
- dout_rdy  in  1  downstream accepts result
- dout  out  64  result after FP
- busy  out  1  high in ROUND or DONE

Behaviour:
- Reset values (async, while rst=1): state=IDLE, cnt=0, L=R=0, dec_q=0, dout=0, dout_vld=0, busy=0. din_rdy=1 after reset. sk_idx=0.
- Reset mid-operation aborts the block; no partial result is ever emitted.
- FSM states: IDLE, ROUND, DONE.
- din_rdy = (state==IDLE) | (state==DONE & dout_rdy).
- Accept: din_vld & din_rdy at edge T. Action: {L,R} <= IP(din), dec_q <= dec, cnt <= 0, state <= ROUND.
- An accept in DONE is simultaneous with output hand-off. Result: back-to-back blocks with no bubble.
- ROUND: sk_idx = dec_q ? 15-cnt : cnt, combinational.
- Each edge in ROUND: L <= R; R <= L ^ P(S(E(R) ^ sk)); cnt <= cnt+1.
- cnt==15 edge:
  - No swap: dout <= FP({L ^ f(R,sk), R}).
  - dout_vld <= 1, state <= DONE.
- Latency: accept at edge T, dout_vld high after edge T+16. Sustained throughput is 1 block per 17 cycles.
- DONE: dout and dout_vld are held stable until dout_rdy=1.
- Hand-off edge:
  - dout_vld <= 0.
  - dout per HOLD_DOUT.
  - state <= ROUND if a new block is accepted, otherwise IDLE.
- din_vld is ignored while din_rdy=0. din and dec are sampled only on accept.
- sk_idx is don't-care outside ROUND and held at 0. sk is ignored outside ROUND.
- cnt is 4 bits and never wraps inside a block; it is reset to 0 on accept.
- S-box addressing follows DES: row = {b5,b0}, column = b4..b1 of each 6-bit group. Group 1 = bits 47:42 of E(R)^sk, feeding S1, whose output lands in bits 31:28 of the P input.

Decomposition:
- Package des_pkg holds:
  - IP, FP, E, P tables as constant index arrays (DES 1-based converted to MSB-first bit indices)
  - state encodings IDLE=2'd0, ROUND=2'd1, DONE=2'd2
  - NUM_ROUNDS=16
- One combinational sub-module, des_f:
  - inputs R[31:0] and sk[47:0]; output f[31:0]
  - performs E, XOR, instantiates des_sbox1..des_sbox8, then applies P
- The engine holds only the FSM, counter, L/R registers, IP/FP and the handshake.

Test Plan:
- Reset, then encrypt: key 133457799BBCDFF1 (bench schedule model drives sk from sk_idx), din=0123456789ABCDEF, dec=0 -> dout=85E813540F0AB405, dout_vld rises exactly 16 cycles after accept, sk_idx sequence 0..15.
- Decrypt: same key, din=85E813540F0AB405, dec=1 -> dout=0123456789ABCDEF, sk_idx sequence 15..0.
- Zero key, din=0000000000000000, dec=0 -> dout=8CA64DE9C1B123A7.
- Backpressure:
  - hold dout_rdy=0 for 10 cycles after dout_vld -> dout stable, din_rdy=0, din_vld toggling ignored.
  - then dout_rdy=1 with din_vld=1 -> hand-off and new accept on the same edge; second result arrives 16 cycles later.
- Assert rst at round 7 -> dout_vld=0, dout=0, state IDLE immediately (async). Next block afterwards gives the correct result.
- HOLD_DOUT=0 build: after hand-off -> dout=0000000000000000. HOLD_DOUT=1 -> previous result retained.
